// File: rtl/core_seq_pkg.sv
// Shared types and constants for the core_op_sequencer slice: FSM state
// encoding, the queued command record, and the fixed phase lengths.
package core_seq_pkg;

    localparam int OP_CFG_WIDTH = 41;
    localparam int STATE_WIDTH  = 32;
    localparam int OP_ID_WIDTH  = 4;

    // Cycles spent in each fixed-length phase of an op.
    localparam int CFG_PULSE_CYCLES   = 1;
    localparam int START_PULSE_CYCLES = 1;
    localparam int WAIT_CLR_CYCLES    = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_START,
        ST_WAIT_CLR,
        ST_BUSY,
        ST_DONE
    } seq_state_e;

    typedef struct packed {
        logic [STATE_WIDTH-1:0]  state;
        logic [OP_CFG_WIDTH-1:0] op_cfg;
        logic [OP_ID_WIDTH-1:0]  id;
    } seq_cmd_t;

    // Length of a fixed-length phase; open-ended states report 1.
    function automatic int phase_len(seq_state_e s);
        case (s)
            ST_CFG:      return CFG_PULSE_CYCLES;
            ST_START:    return START_PULSE_CYCLES;
            ST_WAIT_CLR: return WAIT_CLR_CYCLES;
            default:     return 1;
        endcase
    endfunction

endpackage

// File: rtl/core_op_sequencer_if.sv
// Bundle of the command, core_top and completion signals of the sequencer.
// master = head controller / core side, slave = the sequencer itself.
interface core_op_sequencer_if;
    import core_seq_pkg::*;

    logic                    cmd_vld;
    logic                    cmd_rdy;
    logic [STATE_WIDTH-1:0]  cmd_state;
    logic [OP_CFG_WIDTH-1:0] cmd_op_cfg;
    logic [OP_ID_WIDTH-1:0]  cmd_id;
    logic                    flush;

    logic                    op_cfg_vld;
    logic [OP_CFG_WIDTH-1:0] op_cfg;
    logic [STATE_WIDTH-1:0]  control_state;
    logic                    control_state_update;
    logic                    start;
    logic                    finish;

    logic                    done_vld;
    logic [OP_ID_WIDTH-1:0]  done_id;
    logic                    done_err;
    logic                    busy;

    modport master (
        output cmd_vld, cmd_state, cmd_op_cfg, cmd_id, flush, finish,
        input  cmd_rdy, op_cfg_vld, op_cfg, control_state, control_state_update,
               start, done_vld, done_id, done_err, busy
    );

    modport slave (
        input  cmd_vld, cmd_state, cmd_op_cfg, cmd_id, flush, finish,
        output cmd_rdy, op_cfg_vld, op_cfg, control_state, control_state_update,
               start, done_vld, done_id, done_err, busy
    );

endinterface

// File: rtl/core_seq_cmd_fifo.sv
// Synchronous command FIFO. Flush empties it at the next edge and overrides
// any push or pop in the same cycle. No bypass: a full FIFO refuses pushes.
module core_seq_cmd_fifo
    import core_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  seq_cmd_t wr_data,
    input  logic     pop,
    output seq_cmd_t rd_data,
    input  logic     flush,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = PTR_W + 1;

    seq_cmd_t           mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [COUNT_W-1:0] count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == COUNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Entry storage.
    // NOTE: the array is deliberately not reset; occupancy alone says which
    // entries are valid, so the storage stays a plain register file / RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/core_op_sequencer.sv
// Sequences one core_top through queued ops: load op_cfg, pulse
// control_state_update/start, mask one cycle of stale finish, then wait for
// finish and report completion.
// Optional feature macro: CORE_SEQ_WATCHDOG_EN adds a per-op BUSY watchdog
// that ends a hung op with done_err=1 after TIMEOUT_CYCLES.
module core_op_sequencer
    import core_seq_pkg::*;
#(
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic                clk,
    input logic                rst,
    core_op_sequencer_if.slave bus
);

    seq_state_e state;
    seq_state_e state_next;
    logic [3:0] phase_cnt;
    logic       phase_done;
    seq_cmd_t   cur;
    seq_cmd_t   head;
    seq_cmd_t   wr_cmd;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       err_q;
    logic       err_next;
    logic       wd_expired;

    assign wr_cmd = '{state: bus.cmd_state, op_cfg: bus.cmd_op_cfg, id: bus.cmd_id};

    core_seq_cmd_fifo #(.DEPTH(CMD_FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.cmd_vld),
        .wr_data (wr_cmd),
        .pop     (pop),
        .rd_data (head),
        .flush   (bus.flush),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef CORE_SEQ_WATCHDOG_EN
    logic [31:0] wd_cnt;

    // Count BUSY cycles, restarting from zero on every entry into BUSY.
    always_ff @(posedge clk) begin
        if (rst || state != ST_BUSY) wd_cnt <= '0;
        else                         wd_cnt <= wd_cnt + 32'd1;
    end

    assign wd_expired = (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;

    assign wd_expired     = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    assign phase_done        = (int'(phase_cnt) == phase_len(state) - 1);
    assign bus.cmd_rdy       = !fifo_full;
    assign bus.busy          = (state != ST_IDLE) || !fifo_empty;
    assign bus.op_cfg        = cur.op_cfg;
    assign bus.control_state = cur.state;

    // State, phase timer and latched command registers.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
            cur       <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_next;
            phase_cnt <= (state_next != state) ? '0 : phase_cnt + 1'b1;
            err_q     <= err_next;
            if (pop) cur <= head;
        end
    end

    // Next-state selection and per-state output pulses.
    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        state_next               = state;
        pop                      = 1'b0;
        err_next                 = err_q;
        bus.op_cfg_vld           = 1'b0;
        bus.control_state_update = 1'b0;
        bus.start                = 1'b0;
        bus.done_vld             = 1'b0;
        bus.done_id              = '0;
        bus.done_err             = 1'b0;
        case (state)
            ST_IDLE: begin
                // A flush in this cycle empties the queue, so nothing is taken.
                if (!fifo_empty && !bus.flush) begin
                    pop        = 1'b1;
                    err_next   = 1'b0;
                    state_next = ST_CFG;
                end
            end
            ST_CFG: begin
                bus.op_cfg_vld = 1'b1;
                if (phase_done) state_next = ST_START;
            end
            ST_START: begin
                bus.control_state_update = 1'b1;
                bus.start                = 1'b1;
                if (phase_done) state_next = ST_WAIT_CLR;
            end
            ST_WAIT_CLR: begin
                // finish still reflects the previous op here and is ignored.
                if (phase_done) state_next = ST_BUSY;
            end
            ST_BUSY: begin
                if (bus.finish) begin
                    err_next   = 1'b0;
                    state_next = ST_DONE;
                end else if (wd_expired) begin
                    err_next   = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.done_vld = 1'b1;
                bus.done_id  = cur.id;
                bus.done_err = err_q;
                state_next   = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_core_op_sequencer.sv
// Self-checking bench for core_op_sequencer: directed scenarios with literal
// expectations plus a randomized phase, all outputs compared every cycle
// against a queue-based reference model. Watchdog scenario runs when
// CORE_SEQ_WATCHDOG_EN is defined.
module tb_core_op_sequencer;
    import core_seq_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    core_op_sequencer_if bus();

    core_op_sequencer #(.CMD_FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expired(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait expired without the expected event (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model ----------------
    // Commands live in a queue; an op in flight is tracked by its age in
    // cycles since it was taken: age 1 config pulse, age 2 start pulse,
    // age 3 masked, age >= 4 finish is honoured; done is the following cycle.
    seq_cmd_t mq[$];
    seq_cmd_t mcur   = '0;
    bit       m_in_op = 1'b0;
    bit       m_done  = 1'b0;
    bit       m_err   = 1'b0;
    int       m_age   = 0;
    bit       m_live  = 1'b0;

    initial forever begin
        int  sz;
        bit  pushing;
        bit  popping;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mcur    = '0;
            m_in_op = 1'b0;
            m_done  = 1'b0;
            m_err   = 1'b0;
            m_age   = 0;
            m_live  = 1'b1;
        end else if (m_live) begin
            sz      = mq.size();
            pushing = bus.cmd_vld && (sz < DEPTH) && !bus.flush;
            popping = !m_in_op && (sz > 0) && !bus.flush;
            if (m_in_op) begin
                if (m_done) begin
                    m_in_op = 1'b0;
                    m_done  = 1'b0;
                end else if (m_age >= 4 && bus.finish) begin
                    m_done = 1'b1;
                    m_err  = 1'b0;
`ifdef CORE_SEQ_WATCHDOG_EN
                end else if (m_age >= 4 && (m_age - 3) == TIMEOUT) begin
                    m_done = 1'b1;
                    m_err  = 1'b1;
`endif
                end else begin
                    m_age++;
                end
            end
            if (popping) begin
                mcur    = mq.pop_front();
                m_in_op = 1'b1;
                m_age   = 1;
                m_err   = 1'b0;
            end
            if (bus.flush) mq.delete();
            if (pushing) mq.push_back('{state: bus.cmd_state, op_cfg: bus.cmd_op_cfg, id: bus.cmd_id});
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (m_live) begin
            check("cmd_rdy",    64'(bus.cmd_rdy),              64'(mq.size() < DEPTH));
            check("busy",       64'(bus.busy),                 64'(m_in_op || mq.size() > 0));
            check("op_cfg_vld", 64'(bus.op_cfg_vld),           64'(m_in_op && m_age == 1));
            check("cs_update",  64'(bus.control_state_update), 64'(m_in_op && m_age == 2));
            check("start",      64'(bus.start),                64'(m_in_op && m_age == 2));
            check("done_vld",   64'(bus.done_vld),             64'(m_done));
            check("done_id",    64'(bus.done_id),              m_done ? 64'(mcur.id) : 64'd0);
            check("done_err",   64'(bus.done_err),             64'(m_done && m_err));
            check("op_cfg",     64'(bus.op_cfg),               64'(mcur.op_cfg));
            check("ctrl_state", 64'(bus.control_state),        64'(mcur.state));
        end
    end

    // ---------------- event monitor for literal checks ----------------
    int n_cfg = 0, n_start = 0, n_done = 0;
    int t_cfg = 0, t_start = 0, t_done = 0;
    int done_ids[$];
    bit last_err = 1'b0;

    initial forever begin
        @(negedge clk);
        if (bus.op_cfg_vld) begin n_cfg++; t_cfg = cyc; end
        if (bus.start) begin n_start++; t_start = cyc; end
        if (bus.done_vld) begin
            n_done++;
            t_done   = cyc;
            last_err = bus.done_err;
            done_ids.push_back(int'(bus.done_id));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_cmd(input logic [31:0] st, input logic [40:0] cfg,
                            input logic [3:0] id, output int t_acc);
        int waited = 0;
        bus.cmd_vld    = 1'b1;
        bus.cmd_state  = st;
        bus.cmd_op_cfg = cfg;
        bus.cmd_id     = id;
        while (!bus.cmd_rdy && waited < 200) begin tick(); waited++; end
        if (!bus.cmd_rdy) begin
            expired("push_accept");
            t_acc = -1;
        end else begin
            t_acc = cyc;
        end
        tick();
        bus.cmd_vld = 1'b0;
    endtask

    task automatic wait_starts(input int target, input int max_cyc);
        int k = 0;
        while (n_start < target && k < max_cyc) begin tick(); k++; end
        if (n_start < target) expired("wait_start");
    endtask

    task automatic wait_done(input int max_cyc);
        int base = n_done;
        int k = 0;
        while (n_done == base && k < max_cyc) begin tick(); k++; end
        if (n_done == base) expired("wait_done");
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int          t_acc, t_fin, s_base, c_base, d_base, ts, sz;
        logic [40:0] cfg1;

        bus.cmd_vld    = 1'b0;
        bus.cmd_state  = '0;
        bus.cmd_op_cfg = '0;
        bus.cmd_id     = '0;
        bus.flush      = 1'b0;
        bus.finish     = 1'b0;
        rst            = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_cmd_rdy", 64'(bus.cmd_rdy), 64'd1);
        check("reset_busy",    64'(bus.busy),    64'd0);
        check("reset_op_cfg",  64'(bus.op_cfg),  64'd0);

        // Single op: latency of config/start, done one cycle after finish.
        cfg1   = {10'd32, 10'd1, 16'd0, 5'd9};
        c_base = n_cfg;
        s_base = n_start;
        push_cmd(32'd1, cfg1, 4'd3, t_acc);
        wait_starts(s_base + 1, 20);
        while (cyc < t_start + 20) tick();
        bus.finish = 1'b1;
        t_fin      = cyc;
        wait_done(10);
        bus.finish = 1'b0;
        check("single_cfg_pulses",   64'(n_cfg - c_base),   64'd1);
        check("single_start_pulses", 64'(n_start - s_base), 64'd1);
        check("single_cfg_latency",  64'(t_cfg - t_acc),    64'd2);
        check("single_start_latency",64'(t_start - t_acc),  64'd3);
        check("single_done_latency", 64'(t_done - t_fin),   64'd1);
        check("single_done_id",      64'(done_ids[$]),      64'd3);
        check("single_busy_after",   64'(bus.busy),         64'd0);
        check("single_ctrl_state",   64'(bus.control_state),64'd1);

        // Five back-to-back commands: the first is taken immediately, the
        // other four fill the FIFO, so cmd_rdy is low after the fifth accept.
        s_base = n_start;
        for (int i = 0; i < 5; i++) push_cmd(32'(100 + i), 41'(i), 4'(4 + i), t_acc);
        check("five_rdy_full", 64'(bus.cmd_rdy), 64'd0);
        for (int i = 1; i <= 5; i++) begin
            wait_starts(s_base + i, 30);
            tick();
            bus.finish = 1'b1;
            tick();
            bus.finish = 1'b0;
        end
        tick();
        tick();
        sz = done_ids.size();
        for (int k = 0; k < 5; k++) check("five_order", 64'(done_ids[sz - 5 + k]), 64'(4 + k));

        // finish held high across two ops: completes one cycle after BUSY entry.
        d_base     = n_done;
        bus.finish = 1'b1;
        push_cmd(32'd7, 41'h123, 4'd10, t_acc);
        push_cmd(32'd8, 41'h456, 4'd11, t_acc);
        for (int k = 0; k < 40 && n_done < d_base + 2; k++) tick();
        if (n_done < d_base + 2) expired("held_finish_done");
        bus.finish = 1'b0;
        check("held_done_gap",   64'(t_done - t_start), 64'd3);
        check("held_last_id",    64'(done_ids[$]),      64'd11);

        // Flush with three queued commands and a simultaneous push.
        d_base = n_done;
        s_base = n_start;
        push_cmd(32'd20, 41'h1, 4'd12, t_acc);
        wait_starts(s_base + 1, 20);
        tick();
        for (int i = 0; i < 3; i++) push_cmd(32'(30 + i), 41'(i), 4'(13 + i), t_acc);
        bus.flush      = 1'b1;
        bus.cmd_vld    = 1'b1;
        bus.cmd_id     = 4'd9;
        tick();
        bus.flush   = 1'b0;
        bus.cmd_vld = 1'b0;
        tick();
        bus.finish = 1'b1;
        tick();
        bus.finish = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("flush_done_count", 64'(n_done - d_base), 64'd1);
        check("flush_done_id",    64'(done_ids[$]),     64'd12);
        check("flush_busy",       64'(bus.busy),        64'd0);
        check("flush_cmd_rdy",    64'(bus.cmd_rdy),     64'd1);

        // Reset while BUSY abandons the op.
        d_base = n_done;
        s_base = n_start;
        push_cmd(32'h55, 41'h1ABCD, 4'd1, t_acc);
        push_cmd(32'h66, 41'h2, 4'd2, t_acc);
        wait_starts(s_base + 1, 20);
        tick();
        rst = 1'b1;
        tick();
        check("rst_busy",       64'(bus.busy),          64'd0);
        check("rst_cmd_rdy",    64'(bus.cmd_rdy),       64'd1);
        check("rst_op_cfg",     64'(bus.op_cfg),        64'd0);
        check("rst_ctrl_state", 64'(bus.control_state), 64'd0);
        check("rst_done_vld",   64'(bus.done_vld),      64'd0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check("rst_no_done", 64'(n_done - d_base), 64'd0);

`ifdef CORE_SEQ_WATCHDOG_EN
        // Watchdog: no finish times out after 16 BUSY cycles.
        s_base = n_start;
        push_cmd(32'd2, 41'h3, 4'd2, t_acc);
        wait_starts(s_base + 1, 20);
        ts = t_start;
        wait_done(40);
        check("wd_timeout_gap", 64'(t_done - ts), 64'd18);
        check("wd_timeout_err", 64'(last_err),    64'd1);
        // finish on the 16th BUSY cycle wins over the timeout.
        s_base = n_start;
        push_cmd(32'd3, 41'h4, 4'd3, t_acc);
        wait_starts(s_base + 1, 20);
        ts = t_start;
        while (cyc < ts + 17) tick();
        bus.finish = 1'b1;
        tick();
        bus.finish = 1'b0;
        tick();
        check("wd_race_gap", 64'(t_done - ts), 64'd18);
        check("wd_race_err", 64'(last_err),    64'd0);
`else
        // Without the watchdog an op waits indefinitely for finish.
        d_base = n_done;
        s_base = n_start;
        push_cmd(32'd2, 41'h3, 4'd2, t_acc);
        wait_starts(s_base + 1, 20);
        for (int k = 0; k < 40; k++) tick();
        check("hang_no_done", 64'(n_done - d_base), 64'd0);
        check("hang_busy",    64'(bus.busy),        64'd1);
        bus.finish = 1'b1;
        tick();
        bus.finish = 1'b0;
        tick();
        check("hang_done_id",  64'(done_ids[$]), 64'd2);
        check("hang_done_err", 64'(last_err),    64'd0);
`endif

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            bus.cmd_vld    = ($urandom_range(0, 99) < 40);
            bus.cmd_state  = $urandom();
            bus.cmd_op_cfg = 41'({$urandom(), $urandom()});
            bus.cmd_id     = 4'($urandom_range(0, 15));
            bus.finish     = ($urandom_range(0, 99) < 25);
            bus.flush      = ($urandom_range(0, 99) < 3);
            tick();
        end
        bus.cmd_vld = 1'b0;
        bus.flush   = 1'b0;
        bus.finish  = 1'b1;
        for (int k = 0; k < 60; k++) tick();
        bus.finish = 1'b0;
        tick();
        check("drain_busy", 64'(bus.busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("FAIL global_timeout: simulation did not complete in time");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "global timeout");
    end

endmodule
